// File: rtl/l1i_cache_assoc.sv
// Set-associative L1 instruction cache: PID-tagged lines, round-robin victim choice,
// single-cycle flush, and a miss FSM that waits for the line fill and replays the fetch.
module l1i_cache_assoc #(
   parameter int fetchingAddressWidth    = 64,
   parameter int cacheLineWidth          = 512,
   parameter int instructionWidth        = 32,
   parameter int offsetWidth             = 6,
   parameter int indexWidth              = 6,
   parameter int numWays                 = 4,
   parameter int wayIdxWidth             = 2,
   parameter int bundleInsts             = 4,
   parameter int PidSize                 = 20,
   parameter int TidSize                 = 16,
   parameter int instructionCounterWidth = 64
) (
   input  logic                                    clock_i,
   input  logic                                    cacheReset_i,
   input  logic                                    fetchEnable_i,
   input  logic                                    fetchStall_i,
   input  logic [PidSize-1:0]                      Pid_i,
   input  logic [TidSize-1:0]                      Tid_i,
   input  logic [fetchingAddressWidth-1:0]         fetchAddress_i,
   input  logic                                    cacheUpdate_i,
   input  logic [fetchingAddressWidth-1:0]         cacheUpdateAddress_i,
   input  logic [PidSize-1:0]                      cacheUpdatePid_i,
   input  logic [TidSize-1:0]                      cacheUpdateTid_i,
   input  logic [cacheLineWidth-1:0]               cacheUpdateLine_i,
   input  logic                                    flush_i,
   output logic                                    outputEnable_o,
   output logic [bundleInsts*instructionWidth-1:0] outputBundle_o,
   output logic [fetchingAddressWidth-1:0]         bundleAddress_o,
   output logic [1:0]                              bundleLen_o,
   output logic [PidSize-1:0]                      bundlePid_o,
   output logic [TidSize-1:0]                      bundleTid_o,
   output logic [instructionCounterWidth-1:0]      bundleStartMajId_o,
   output logic                                    cacheMiss_o,
   output logic [fetchingAddressWidth-1:0]         missedAddress_o,
   output logic [instructionCounterWidth-1:0]      missedInstMajorId_o,
   output logic [PidSize-1:0]                      missedPid_o,
   output logic [TidSize-1:0]                      missedTid_o
);

   localparam int tagWidth     = fetchingAddressWidth - indexWidth - offsetWidth;
   localparam int numSets      = 1 << indexWidth;
   localparam int instsPerLine = cacheLineWidth / instructionWidth;
   localparam int bundleWidth  = bundleInsts * instructionWidth;
   localparam int instShift    = $clog2(instructionWidth / 8);
   localparam int slotWidth    = offsetWidth - instShift;
   localparam logic [slotWidth:0] lineInsts = (slotWidth+1)'(instsPerLine);
   localparam logic [slotWidth:0] maxInsts  = (slotWidth+1)'(bundleInsts);
   localparam logic [slotWidth:0] cntOne    = (slotWidth+1)'(1);
   localparam logic [wayIdxWidth-1:0] lastWay = wayIdxWidth'(numWays - 1);
   localparam logic [wayIdxWidth-1:0] wayOne  = wayIdxWidth'(1);

   typedef enum logic [1:0] {IDLE, MISS, REPLAY} state_t;
   state_t state_q, state_d;

   logic [numWays-1:0]                 valid_q [numSets];
   logic [wayIdxWidth-1:0]             rr_q    [numSets];
   logic [tagWidth-1:0]                tag_q   [numSets][numWays];
   logic [PidSize-1:0]                 pid_q   [numSets][numWays];
   logic [cacheLineWidth-1:0]          line_q  [numSets][numWays];
   logic [instructionCounterWidth-1:0] maj_cnt_q;

   logic [fetchingAddressWidth-1:0] look_addr;
   logic [PidSize-1:0]              look_pid;
   logic [TidSize-1:0]              look_tid;
   logic [indexWidth-1:0]           look_index;
   logic [tagWidth-1:0]             look_tag;
   logic                            hit;
   logic [wayIdxWidth-1:0]          hit_way;
   logic [cacheLineWidth-1:0]       hit_line;
   logic [slotWidth-1:0]            first_inst;
   logic [slotWidth:0]              avail;
   logic [slotWidth:0]              count;
   logic [bundleWidth-1:0]          bundle_data;

   logic [indexWidth-1:0]  fill_index;
   logic [tagWidth-1:0]    fill_tag;
   logic                   fill_we;
   logic                   fill_hits_miss;
   logic                   fill_match;
   logic                   fill_free;
   logic [wayIdxWidth-1:0] fill_match_way;
   logic [wayIdxWidth-1:0] fill_free_way;
   logic [wayIdxWidth-1:0] fill_way;
   logic                   fill_bump;

   logic emit;
   logic take_miss;
   logic unused_fill_bits;

   assign unused_fill_bits = ^{cacheUpdateTid_i, cacheUpdateAddress_i[offsetWidth-1:0]};

   // The replay cycle reuses the lookup port with the latched missed request.
   always_comb begin
      look_addr = fetchAddress_i;
      look_pid  = Pid_i;
      look_tid  = Tid_i;
      if (state_q == REPLAY) begin
         look_addr = missedAddress_o;
         look_pid  = missedPid_o;
         look_tid  = missedTid_o;
      end
   end

   assign look_index = look_addr[offsetWidth +: indexWidth];
   assign look_tag   = look_addr[fetchingAddressWidth-1 -: tagWidth];

   // Descending scan so that the lowest matching way wins.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = numWays - 1; w >= 0; w--) begin
         if (valid_q[look_index][w] && tag_q[look_index][w] == look_tag &&
             pid_q[look_index][w] == look_pid) begin
            hit     = 1'b1;
            hit_way = wayIdxWidth'(w);
         end
      end
   end

   assign hit_line   = line_q[look_index][hit_way];
   assign first_inst = look_addr[instShift +: slotWidth];

   always_comb begin
      avail       = lineInsts - {1'b0, first_inst};
      count       = (avail < maxInsts) ? avail : maxInsts;
      bundle_data = '0;
      for (int s = 0; s < bundleInsts; s++) begin
         if (s < int'(count)) begin
            bundle_data[bundleWidth-1-s*instructionWidth -: instructionWidth] =
               hit_line[cacheLineWidth-1-(int'(first_inst)+s)*instructionWidth -: instructionWidth];
         end
      end
   end

   assign fill_index     = cacheUpdateAddress_i[offsetWidth +: indexWidth];
   assign fill_tag       = cacheUpdateAddress_i[fetchingAddressWidth-1 -: tagWidth];
   assign fill_we        = cacheUpdate_i && !flush_i;
   assign fill_hits_miss = fill_index == missedAddress_o[offsetWidth +: indexWidth] &&
                           fill_tag == missedAddress_o[fetchingAddressWidth-1 -: tagWidth] &&
                           cacheUpdatePid_i == missedPid_o;

   // Victim: refresh an existing copy, else the lowest free way, else the RR way.
   always_comb begin
      fill_match     = 1'b0;
      fill_free      = 1'b0;
      fill_match_way = '0;
      fill_free_way  = '0;
      for (int w = numWays - 1; w >= 0; w--) begin
         if (valid_q[fill_index][w] && tag_q[fill_index][w] == fill_tag &&
             pid_q[fill_index][w] == cacheUpdatePid_i) begin
            fill_match     = 1'b1;
            fill_match_way = wayIdxWidth'(w);
         end
         if (!valid_q[fill_index][w]) begin
            fill_free     = 1'b1;
            fill_free_way = wayIdxWidth'(w);
         end
      end
      fill_bump = 1'b0;
      if (fill_match) begin
         fill_way = fill_match_way;
      end else if (fill_free) begin
         fill_way = fill_free_way;
      end else begin
         fill_way  = rr_q[fill_index];
         fill_bump = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      emit      = 1'b0;
      take_miss = 1'b0;
      if (!fetchStall_i) begin
         case (state_q)
            IDLE: begin
               if (fetchEnable_i) begin
                  if (hit) begin
                     emit = 1'b1;
                  end else begin
                     take_miss = 1'b1;
                     state_d   = MISS;
                  end
               end
            end
            MISS: begin
               if (fill_we && fill_hits_miss) state_d = REPLAY;
            end
            REPLAY: begin
               if (hit) begin
                  emit    = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = MISS;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      if (flush_i) begin
         state_d   = IDLE;
         emit      = 1'b0;
         take_miss = 1'b0;
      end
   end

   always_ff @(posedge clock_i) begin
      if (!cacheReset_i) state_q <= IDLE;
      else               state_q <= state_d;
   end

   assign cacheMiss_o = (state_q == MISS);

   always_ff @(posedge clock_i) begin
      if (!cacheReset_i) begin
         for (int s = 0; s < numSets; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else if (flush_i) begin
         for (int s = 0; s < numSets; s++) valid_q[s] <= '0;
      end else if (cacheUpdate_i) begin
         valid_q[fill_index][fill_way] <= 1'b1;
         if (fill_bump) begin
            rr_q[fill_index] <= (rr_q[fill_index] == lastWay) ? '0 : rr_q[fill_index] + wayOne;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (cacheReset_i && fill_we) begin
         tag_q[fill_index][fill_way]  <= fill_tag;
         pid_q[fill_index][fill_way]  <= cacheUpdatePid_i;
         line_q[fill_index][fill_way] <= cacheUpdateLine_i;
      end
   end

   // Output stage: bundle registers, major counter and missed-request latch.
   always_ff @(posedge clock_i) begin
      if (!cacheReset_i) begin
         outputEnable_o      <= 1'b0;
         outputBundle_o      <= '0;
         bundleAddress_o     <= '0;
         bundleLen_o         <= '0;
         bundlePid_o         <= '0;
         bundleTid_o         <= '0;
         bundleStartMajId_o  <= '0;
         missedAddress_o     <= '0;
         missedInstMajorId_o <= '0;
         missedPid_o         <= '0;
         missedTid_o         <= '0;
         maj_cnt_q           <= '0;
      end else if (flush_i) begin
         outputEnable_o <= 1'b0;
      end else if (!fetchStall_i) begin
         outputEnable_o <= emit;
         if (emit) begin
            outputBundle_o     <= bundle_data;
            bundleAddress_o    <= look_addr;
            bundleLen_o        <= 2'(count - cntOne);
            bundlePid_o        <= look_pid;
            bundleTid_o        <= look_tid;
            bundleStartMajId_o <= maj_cnt_q;
            maj_cnt_q          <= maj_cnt_q + instructionCounterWidth'(count);
         end
         if (take_miss) begin
            missedAddress_o     <= fetchAddress_i;
            missedInstMajorId_o <= maj_cnt_q;
            missedPid_o         <= Pid_i;
            missedTid_o         <= Tid_i;
         end
      end
   end

endmodule

// File: doc/l1i_cache_assoc.md
Name: l1i_cache_assoc

Overview:
Parametrised N-way set-associative successor to the direct-mapped L1 instruction cache in the fetch stage. Tags each line with PID, returns a variable-length bundle (1..bundleInsts instructions, unaligned start, never crossing a line) one cycle after a fetch hit. On a miss, a miss FSM holds the request, accepts the line fill, and replays the missed fetch. Adds per-set round-robin replacement and single-cycle flush.

Parameters:
fetchingAddressWidth, 64, fetch/fill address width
cacheLineWidth, 512, line size in bits (64 B)
instructionWidth, 32, fixed instruction size
offsetWidth, 6, byte offset within line
indexWidth, 6, set index bits (64 sets)
numWays, 4, associativity (power of two, >=1)
wayIdxWidth, 2, log2(numWays) (min 1)
bundleInsts, 4, maximum instructions per bundle
PidSize, 20, process ID width
TidSize, 16, thread ID width
instructionCounterWidth, 64, major ID counter width
Derived tagWidth = fetchingAddressWidth-indexWidth-offsetWidth.

Ports:
clock_i  in  1  clock, all state on rising edge
cacheReset_i  in  1  synchronous, active-low reset
fetchEnable_i  in  1  fetch request valid
fetchStall_i  in  1  downstream stall, freezes block
Pid_i / Tid_i  in  PidSize / TidSize  requester IDs
fetchAddress_i  in  fetchingAddressWidth  fetch byte address (4-byte aligned)
cacheUpdate_i  in  1  line fill valid
cacheUpdateAddress_i  in  fetchingAddressWidth  fill address (offset ignored)
cacheUpdatePid_i / cacheUpdateTid_i  in  PidSize / TidSize  fill owner
cacheUpdateLine_i  in  cacheLineWidth  fill data, instruction 0 at MSBs
flush_i  in  1  invalidate all lines
outputEnable_o  out  1  bundle valid
outputBundle_o  out  bundleInsts*instructionWidth  bundle, left-justified, unused slots zero
bundleAddress_o  out  fetchingAddressWidth  address of first instruction
bundleLen_o  out  2  instruction count minus 1
bundlePid_o / bundleTid_o  out  PidSize / TidSize  request IDs
bundleStartMajId_o  out  instructionCounterWidth  major ID of first instruction
cacheMiss_o  out  1  miss outstanding (level)
missedAddress_o  out  fetchingAddressWidth  missed fetch address
missedInstMajorId_o  out  instructionCounterWidth  counter value at miss
missedPid_o / missedTid_o  out  PidSize / TidSize  missed request IDs

Behaviour:
- Reset (cacheReset_i==0): all valid bits 0, RR pointers 0, major counter 0, state IDLE, every output 0. Highest priority, including mid-miss.
- Priority per cycle: reset > flush > fetchStall (freezes FSM, outputs, counter; fills still written) > fill > fetch.
- Hit: valid && tag match && stored PID==Pid_i in set[index]. At most one way hits; multiple hits are a fill bug, lowest way wins.
- Latency 1: fetch hit at edge N -> outputEnable_o=1 after edge N for one cycle (0 otherwise).
- Bundle: i = offset>>2; count = min(bundleInsts, 16-i); bundleLen_o=count-1; bundleStartMajId_o=counter; counter += count (wraps modulo 2^width).
- States: IDLE, MISS, REPLAY.
- IDLE + fetch miss -> MISS; latch missed* from request; cacheMiss_o=1 from next cycle until fill; further fetches ignored, outputEnable_o=0.
- MISS + fill with matching tag/index and PID -> write line, REPLAY; cacheMiss_o drops same edge. Non-matching fill: written, stay MISS.
- REPLAY: emit bundle for missedAddress_o (as a hit, counter advances), -> IDLE; fetch inputs ignored this cycle.
- Fill placement: if line+PID already valid in set, overwrite that way, pointer unchanged; else first invalid way (lowest index), else way[RR pointer], then pointer += 1 mod numWays. Fills in IDLE are natural writes.
- Same-cycle fill and fetch to same line in IDLE: fetch sees pre-fill contents (read-before-write) -> miss.
- flush_i: clear all valid bits, RR pointers unchanged, abort MISS/REPLAY -> IDLE, cacheMiss_o=0 next cycle; a same-cycle fill is dropped.

Test Plan:
- Reset then fill lines 0x000..0x240 (PID 0), fetch 0x000,0x010,... -> every cycle outputEnable_o=1, bundleLen_o=3, majIds 0,4,8...; cacheMiss_o never set.
- Fetch 0x038 after fill -> bundleLen_o=1 (2 instrs), slots 2-3 zero; fetch 0x03C -> len 0.
- Fetch 0x1000 (unfilled) -> cacheMiss_o=1, missedAddress_o=0x1000, missedInstMajorId_o=current counter; fill 0x2000 -> stays miss; fill 0x1000 -> cacheMiss_o=0, replay bundle for 0x1000 next cycle.
- Fill 5 lines mapping to set 0 (tags 0..4, 4 ways) -> line tag 0 evicted (RR pointer 0), fetch tag 0 misses, tags 1..4 hit.
- Fill line PID 3, fetch same address PID 5 -> miss; PID 3 -> hit.
- Assert flush_i, and separately cacheReset_i=0 during MISS -> cacheMiss_o=0, state IDLE, all previously hitting fetches now miss.
